cache_miss_refill_ctrl: RTL
===========================

// Module: cache_miss_refill_ctrl
// PURPOSE
//  Miss handler directly downstream of the 4-way L1 data cache. Accepts one missing load/store
//  (cacheMiss=1), fetches the 64 B line from main memory as 16 x 32-bit beats, and chooses a victim way
//  with per-set round-robin. It writes the line back into the cache and replays the original request.
//  Blocking: at most one outstanding miss; the LSQ stalls while busy=1.
// PARAMETERS
//  INDEX_W   7   set index width (addr[12:6]); 2**INDEX_W sets
//  OFFSET_W  6   byte offset width; line = 2**OFFSET_W bytes
//  TAG_W     19  tag width (addr[31:13])
//  BEAT_W    32  memory data beat width; beats/line = 8*2**OFFSET_W/BEAT_W (16)
//  NUM_WAYS  4   associativity; victim pointer is log2(NUM_WAYS) bits
// PORTS
//  clk              in   1    clock, all state on rising edge
//  rst              in   1    asynchronous active-high reset
//  miss_valid       in   1    cache reports miss for the request below
//  miss_ready       out  1    =1 only in IDLE; miss accepted when miss_valid&miss_ready
//  miss_pc          in   32   PC of missing instruction
//  miss_addr        in   32   byte address of missing access
//  miss_is_store    in   1    0 load, 1 store
//  miss_store_size  in   1    0 halfword, 1 byte (cache storeSize encoding)
//  miss_data_sw     in   32   store data
//  mem_req          out  1    line read request, held until mem_gnt
//  mem_addr         out  32   {tag,index,6'b0}, line aligned
//  mem_gnt          in   1    memory accepted request
//  mem_rvalid       in   1    one beat valid on mem_rdata
//  mem_rdata        in   32   beat data, lowest address first
//  refill_valid     out  1    one-cycle write strobe into cache arrays
//  refill_index     out  7    set to write
//  refill_way       out  2    victim way
//  refill_tag       out  19   tag to install (valid bit set by cache)
//  refill_line      out  512  assembled line; beat k in bits [32k+31:32k]
//  replay_valid     out  1    replayed request valid, held until replay_ready
//  replay_ready     in   1    cache accepts replay
//  replay_pc/addr   out  32   captured miss_pc / miss_addr
//  replay_is_store, replay_store_size out 1; replay_data_sw out 32 - captured fields
//  busy             out  1    =1 in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, beat_cnt=0, all RR pointers=0, every output 0 except miss_ready=1.
//  - IDLE: on miss_valid, capture all miss_* fields; go to REQ next cycle.
//  - REQ: mem_req=1, mem_addr stable; on mem_gnt go to FILL. mem_rvalid in REQ is ignored.
//  - FILL: each mem_rvalid writes mem_rdata into slot beat_cnt and increments it. When the beat with
//    beat_cnt=15 arrives, go to REFILL with beat_cnt wrapping to 0. Gaps between beats are allowed.
//  - REFILL: refill_valid=1 for exactly one cycle with index/tag from the captured address and
//    way=rr_ptr[index]; rr_ptr[index] increments mod NUM_WAYS (3->0). Go to REPLAY.
//  - REPLAY: replay_* driven from the captured fields; on replay_ready go to IDLE (miss_ready=1 next cycle).
//  - Minimum latency, accept to replay_valid: 2 + grant wait + 16 beats + 1 cycle.
//  - mem_rvalid beyond 16 beats or outside FILL: dropped; does not affect the line.
//  - Reset mid-operation (any state): abort immediately; line buffer contents are don't-care,
//    no refill_valid/replay_valid is produced, and the RR pointers clear to 0.
//  - The stored line has no store merge; the replayed store performs the write on the hit path.
// CONFIGURATION
//  MISS_PERF_CNT_EN defined: adds output miss_count[31:0]. It is 0 on reset, +1 on each accepted
//   miss and saturates at 32'hFFFF_FFFF. It also adds output fill_cycles[31:0]: cycles spent in
//   REQ+FILL, also saturating.
//  Undefined: neither port nor the counters exist; all other behaviour is identical.
// TESTING
//  1 load miss addr 0x0000_2A48, gnt 1 cyc later, 16 back-to-back beats 0..15 -> mem_addr 0x0000_2A40;
//    refill index 0x29, tag 0x1, way 0, line word k = k; then replay with addr 0x2A48.
//  2 four misses to set 5 with different tags -> refill_way 0,1,2,3; fifth miss -> way 0.
//  3 beats with random 0-3 cycle gaps and mem_gnt delayed 5 cycles -> same line; refill_valid exactly 1 cyc.
//  4 miss_valid asserted in FILL -> ignored (miss_ready=0); accepted only after replay_ready.
//  5 rst pulsed after beat 7 -> no refill_valid; next miss gets way 0 and a clean 16-beat fill.
//  6 (MISS_PERF_CNT_EN) 3 misses -> miss_count=3; gnt delay 2 + 16 beats with no gaps -> fill_cycles +18 per miss.

Source files
------------

// File: rtl/cache_miss_refill_ctrl.sv
// ============================================================================
// Module      : cache_miss_refill_ctrl
// Description : Blocking miss handler for the 4-way L1 data cache. Captures
//               a single missing load/store, reads the 64 B line from main
//               memory as 16 x 32-bit beats, picks a victim way with per-set
//               round-robin, writes the line into the cache arrays and then
//               replays the original request to the cache.
//
// Ports       : clk, rst                 clock / asynchronous active-high reset
//               miss_*                   miss request in (valid/ready handshake)
//               mem_req/addr/gnt         line read request to main memory
//               mem_rvalid/rdata         returning data beats, lowest first
//               refill_*                 one-cycle write strobe into the cache
//               replay_*                 replayed request (valid/ready)
//               busy                     high whenever a miss is in flight
//               miss_count, fill_cycles  saturating perf counters (optional)
//
// Config      : define MISS_PERF_CNT_EN to add the miss_count and
//               fill_cycles outputs and their counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_miss_refill_ctrl #(
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 6,
    parameter int TAG_W    = 19,
    parameter int BEAT_W   = 32,
    parameter int NUM_WAYS = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [31:0]                   miss_pc,
    input  logic [31:0]                   miss_addr,
    input  logic                          miss_is_store,
    input  logic                          miss_store_size,
    input  logic [31:0]                   miss_data_sw,

    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [BEAT_W-1:0]             mem_rdata,

    output logic                          refill_valid,
    output logic [INDEX_W-1:0]            refill_index,
    output logic [$clog2(NUM_WAYS)-1:0]   refill_way,
    output logic [TAG_W-1:0]              refill_tag,
    output logic [8*(2**OFFSET_W)-1:0]    refill_line,

    output logic                          replay_valid,
    input  logic                          replay_ready,
    output logic [31:0]                   replay_pc,
    output logic [31:0]                   replay_addr,
    output logic                          replay_is_store,
    output logic                          replay_store_size,
    output logic [31:0]                   replay_data_sw,

    output logic                          busy
`ifdef MISS_PERF_CNT_EN
    ,
    output logic [31:0]                   miss_count,
    output logic [31:0]                   fill_cycles
`endif
);

    localparam int c_LINE_W   = 8 * (2**OFFSET_W);
    localparam int c_BEATS    = c_LINE_W / BEAT_W;
    localparam int c_CNT_W    = $clog2(c_BEATS);
    localparam int c_WAY_W    = $clog2(NUM_WAYS);
    localparam int c_NUM_SETS = 2**INDEX_W;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_WAY_W-1:0] c_LAST_WAY  = c_WAY_W'(NUM_WAYS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_REQ    = 3'd1;
    localparam logic [2:0] c_S_FILL   = 3'd2;
    localparam logic [2:0] c_S_REFILL = 3'd3;
    localparam logic [2:0] c_S_REPLAY = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic [31:0]         r_pc;
    logic [31:0]         r_addr;
    logic                r_is_store;
    logic                r_store_size;
    logic [31:0]         r_data_sw;

    logic [c_CNT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0]   r_line [c_BEATS];
    logic [c_WAY_W-1:0]  r_rr   [c_NUM_SETS];

    logic                w_accept;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_refill_fire;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;

    assign w_accept      = miss_valid && (r_state == c_S_IDLE);
    // Beats are only meaningful while filling; anything else is dropped.
    assign w_beat        = mem_rvalid && (r_state == c_S_FILL);
    assign w_last_beat   = w_beat && (r_beat_cnt == c_LAST_BEAT);
    assign w_refill_fire = (r_state == c_S_REFILL);
    assign w_index       = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag         = r_addr[OFFSET_W + INDEX_W +: TAG_W];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (miss_valid)   w_state_nxt = c_S_REQ;
            c_S_REQ:    if (mem_gnt)      w_state_nxt = c_S_FILL;
            c_S_FILL:   if (w_last_beat)  w_state_nxt = c_S_REFILL;
            c_S_REFILL:                   w_state_nxt = c_S_REPLAY;
            c_S_REPLAY: if (replay_ready) w_state_nxt = c_S_IDLE;
            default:                      w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        miss_ready   = 1'b0;
        mem_req      = 1'b0;
        refill_valid = 1'b0;
        replay_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            c_S_IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
            end
            c_S_REQ:    mem_req      = 1'b1;
            c_S_FILL:   ;
            c_S_REFILL: refill_valid = 1'b1;
            c_S_REPLAY: replay_valid = 1'b1;
            default: begin
                miss_ready = 1'b0;
                busy       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured miss request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= '0;
            r_addr       <= '0;
            r_is_store   <= 1'b0;
            r_store_size <= 1'b0;
            r_data_sw    <= '0;
        end else if (w_accept) begin
            r_pc         <= miss_pc;
            r_addr       <= miss_addr;
            r_is_store   <= miss_is_store;
            r_store_size <= miss_store_size;
            r_data_sw    <= miss_data_sw;
        end
    end

    // ------------------------------------------------------------------
    // Beat counter and line buffer. The counter wraps to 0 on the last
    // beat, so it is already primed for the next miss.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            for (int k = 0; k < c_BEATS; k++) begin
                r_line[k] <= '0;
            end
        end else if (w_beat) begin
            r_line[r_beat_cnt] <= mem_rdata;
            r_beat_cnt         <= r_beat_cnt + c_CNT_W'(1);
        end
    end

    always_comb begin
        refill_line = '0;
        for (int k = 0; k < c_BEATS; k++) begin
            refill_line[k*BEAT_W +: BEAT_W] = r_line[k];
        end
    end

    // ------------------------------------------------------------------
    // Per-set round-robin victim pointers, advanced on each refill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < c_NUM_SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else if (w_refill_fire) begin
            if (r_rr[w_index] == c_LAST_WAY) begin
                r_rr[w_index] <= '0;
            end else begin
                r_rr[w_index] <= r_rr[w_index] + c_WAY_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output fields derived from the captured request
    // ------------------------------------------------------------------
    assign mem_addr          = {w_tag, w_index, {OFFSET_W{1'b0}}};
    assign refill_index      = w_index;
    assign refill_tag        = w_tag;
    assign refill_way        = r_rr[w_index];
    assign replay_pc         = r_pc;
    assign replay_addr       = r_addr;
    assign replay_is_store   = r_is_store;
    assign replay_store_size = r_store_size;
    assign replay_data_sw    = r_data_sw;

`ifdef MISS_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_miss_count;
    logic [31:0] r_fill_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_count  <= '0;
            r_fill_cycles <= '0;
        end else begin
            if (w_accept && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (((r_state == c_S_REQ) || (r_state == c_S_FILL)) &&
                (r_fill_cycles != 32'hFFFF_FFFF)) begin
                r_fill_cycles <= r_fill_cycles + 32'd1;
            end
        end
    end

    assign miss_count  = r_miss_count;
    assign fill_cycles = r_fill_cycles;
`endif

endmodule

`default_nettype wire
